// File: rtl/letc_core_pkg.sv
// letc_core_pkg: shared types and constants for the LETC core fetch front end.
//   pc_t        32-bit program counter
//   f1_to_f2_s  registered F1 -> F2 bundle {valid, fetch_addr, misaligned}
//   f1_state_e  F1 control state
//   PC_INCR     sequential fetch increment
package letc_core_pkg;

    typedef logic [31:0] pc_t;

    typedef struct packed {
        logic valid;
        pc_t  fetch_addr;
        logic misaligned;
    } f1_to_f2_s;

    typedef enum logic [1:0] {
        F1_BOOT,
        F1_RUN,
        F1_MISALIGN_WAIT
    } f1_state_e;

    localparam pc_t PC_INCR = 32'd4;

endpackage

// File: rtl/letc_core_stage_f1.sv
// letc_core_stage_f1: first fetch stage, owns the PC and issues one fetch address per cycle to F2.
//   i_clk / i_rst_n      clock, asynchronous active-low reset
//   o_stage_ready        high once out of BOOT
//   i_stage_flush        squash the issued address (replayed on the next advance)
//   i_stage_stall        hold all state
//   i_f2_ready           F2 consumes the current output this cycle
//   i_redirect_valid/addr load a new PC (one bubble)
//   o_f1_to_f2           registered {valid, fetch_addr, misaligned}
// Build option: LETC_CORE_F1_MISALIGN_CHECK_EN keeps misaligned redirect targets, flags
// them on issue and parks in MISALIGN_WAIT until the next redirect. Without it, targets
// are word-aligned on load and misaligned is always 0.
module letc_core_stage_f1
    import letc_core_pkg::*;
#(
    parameter pc_t RESET_PC = 32'h0000_0000
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    output logic      o_stage_ready,
    input  logic      i_stage_flush,
    input  logic      i_stage_stall,
    input  logic      i_f2_ready,
    input  logic      i_redirect_valid,
    input  pc_t       i_redirect_addr,
    output f1_to_f2_s o_f1_to_f2
);

`ifdef LETC_CORE_F1_MISALIGN_CHECK_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    f1_state_e state_q, state_d;
    pc_t       pc_q, pc_d;
    f1_to_f2_s out_q, out_d;
    pc_t       target;
    logic      adv;
    logic      mis;

    assign adv    = !i_stage_stall && i_f2_ready;
    assign target = MIS_EN ? i_redirect_addr : (i_redirect_addr & ~32'd3);
    assign mis    = MIS_EN && (pc_q[1:0] != 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= F1_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            F1_BOOT:          state_d = F1_RUN;
            F1_RUN:           state_d = (!i_redirect_valid && !i_stage_flush && adv && mis) ? F1_MISALIGN_WAIT : F1_RUN;
            F1_MISALIGN_WAIT: state_d = i_redirect_valid ? F1_RUN : F1_MISALIGN_WAIT;
            default:          state_d = F1_BOOT;
        endcase
    end

    // Redirect beats flush beats hold beats advance; BOOT ignores everything.
    always_comb begin
        pc_d  = pc_q;
        out_d = out_q;
        if (state_q != F1_BOOT) begin
            if (i_redirect_valid) begin
                pc_d        = target;
                out_d.valid = 1'b0;
            end else if (i_stage_flush) begin
                out_d.valid = 1'b0;
                // Rewind so the squashed address is issued again.
                if (state_q == F1_RUN && out_q.valid)
                    pc_d = out_q.fetch_addr;
            end else if (adv) begin
                if (state_q == F1_RUN) begin
                    out_d = '{valid: 1'b1, fetch_addr: pc_q, misaligned: mis};
                    pc_d  = mis ? pc_q : pc_q + PC_INCR;
                end else begin
                    out_d.valid = 1'b0;
                end
            end
        end
    end

    assign o_stage_ready = (state_q != F1_BOOT);
    assign o_f1_to_f2    = out_q;

endmodule

// File: tb/tb_letc_core_stage_f1.sv
// tb_letc_core_stage_f1: self-checking bench for letc_core_stage_f1 (directed table, corner sequences, randomized vs. reference model).
module tb_letc_core_stage_f1;
    import letc_core_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      stage_ready;
    logic      flush, stall, f2_ready, rv;
    pc_t       raddr;
    f1_to_f2_s out;

    int total = 0;
    int bad   = 0;

`ifdef LETC_CORE_F1_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    localparam logic [31:0] RST_PC = 32'h100;

    letc_core_stage_f1 #(.RESET_PC(RST_PC)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_stage_ready    (stage_ready),
        .i_stage_flush    (flush),
        .i_stage_stall    (stall),
        .i_f2_ready       (f2_ready),
        .i_redirect_valid (rv),
        .i_redirect_addr  (raddr),
        .o_f1_to_f2       (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, rdy, rv;
        logic [31:0] raddr;
        logic        e_valid;
        logic [31:0] e_addr;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic v, input logic [31:0] a);
        stall = s; flush = f; f2_ready = r; rv = v; raddr = a;
    endtask

    task automatic step_chk(input string nm, input logic s, input logic f, input logic r, input logic v,
                            input logic [31:0] a, input logic ev, input logic [31:0] ea, input logic em);
        drive(s, f, r, v, a);
        @(posedge clk); #1;
        chk(nm, {ev ? out.fetch_addr : 32'h0, out.valid, out.valid ? out.misaligned : 1'b0}, {ev ? ea : 32'h0, ev, ev ? em : 1'b0});
    endtask

    // Reference model state, described in terms of the stage's observable behaviour.
    bit          m_boot, m_wait, m_valid, m_mis;
    logic [31:0] m_pc, m_addr;

    task automatic model_reset();
        m_boot = 1; m_wait = 0; m_valid = 0; m_mis = 0; m_pc = RST_PC; m_addr = 0;
    endtask

    task automatic model_step();
        if (m_boot) begin
            m_boot = 0;
        end else if (rv) begin
            m_pc    = MIS_EN ? raddr : (raddr / 4) * 4;
            m_valid = 0;
            m_wait  = 0;
        end else if (flush) begin
            if (m_valid && !m_wait) m_pc = m_addr;
            m_valid = 0;
        end else if (!stall && f2_ready) begin
            if (m_wait) begin
                m_valid = 0;
            end else begin
                m_valid = 1;
                m_addr  = m_pc;
                m_mis   = MIS_EN && (m_pc % 4 != 0);
                if (m_mis) m_wait = 1;
                else m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic async_reset_chk(input string nm);
        #2 rst_n = 1'b0;
        #1;
        chk({nm, "_out"}, out, '0);
        chk({nm, "_rdy"}, stage_ready, 1'b0);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    vec_t vecs[$];

    initial begin
        // stall flush rdy rv raddr | valid addr
        vecs = '{
            '{0,0,1,0,32'h0,        0, 32'h0},
            '{0,0,1,0,32'h0,        1, 32'h100},
            '{0,0,1,0,32'h0,        1, 32'h104},
            '{0,0,0,0,32'h0,        1, 32'h104},
            '{0,0,0,0,32'h0,        1, 32'h104},
            '{0,0,0,0,32'h0,        1, 32'h104},
            '{0,0,1,0,32'h0,        1, 32'h108},
            '{1,1,1,1,32'h2000,     0, 32'h108},
            '{0,0,1,0,32'h0,        1, 32'h2000},
            '{0,0,1,0,32'h0,        1, 32'h2004},
            '{0,0,1,1,32'h40,       0, 32'h2004},
            '{0,0,1,0,32'h0,        1, 32'h40},
            '{0,1,1,0,32'h0,        0, 32'h40},
            '{0,0,1,0,32'h0,        1, 32'h40},
            '{0,0,1,0,32'h0,        1, 32'h44},
            '{0,0,1,1,32'hFFFFFFFC, 0, 32'h44},
            '{0,0,1,0,32'h0,        1, 32'hFFFFFFFC},
            '{0,0,1,0,32'h0,        1, 32'h0},
            '{0,0,1,0,32'h0,        1, 32'h4},
            '{1,0,1,0,32'h0,        1, 32'h4}
        };

        rst_n = 1'b0;
        drive(0, 0, 1, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out, '0);
        chk("reset_ready", stage_ready, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].rdy, vecs[i].rv, vecs[i].raddr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), {out.valid, out.fetch_addr, out.misaligned},
                {vecs[i].e_valid, vecs[i].e_addr, 1'b0});
            if (i == 0) chk("ready_after_boot", stage_ready, 1'b1);
        end

        // Misaligned redirect handling.
        step_chk("mis_redir", 0, 0, 1, 1, 32'h1002, 0, 32'h0, 0);
`ifdef LETC_CORE_F1_MISALIGN_CHECK_EN
        step_chk("mis_issue", 0, 0, 1, 0, 32'h0, 1, 32'h1002, 1);
        step_chk("mis_wait1", 0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        step_chk("mis_wait2", 0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        step_chk("mis_flush", 0, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        step_chk("mis_wait3", 0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
`else
        step_chk("mis_issue", 0, 0, 1, 0, 32'h0, 1, 32'h1000, 0);
        step_chk("mis_next",  0, 0, 1, 0, 32'h0, 1, 32'h1004, 0);
`endif
        step_chk("resume_redir", 0, 0, 1, 1, 32'h3000, 0, 32'h0, 0);
        step_chk("resume_issue", 0, 0, 1, 0, 32'h0, 1, 32'h3000, 0);
        step_chk("resume_next",  0, 0, 1, 0, 32'h0, 1, 32'h3004, 0);

        // Randomized run against the reference model, with an async reset in the middle.
        async_reset_chk("async_rst_a");
        for (int c = 0; c < 600; c++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            drive($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                  $urandom_range(9) == 0, a);
            model_step();
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_out", c), {out.valid, out.fetch_addr, out.misaligned},
                {m_valid, m_addr, m_mis});
            chk($sformatf("rnd%0d_rdy", c), stage_ready, !m_boot);
            if (c == 300) async_reset_chk("async_rst_b");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/letc_core_stage_f1.md
# letc_core_stage_f1

First fetch stage of the LETC core pipeline. Owns the program counter and issues one aligned fetch address per cycle to F2 through a registered `f1_to_f2_s` bundle. Handles reset boot, sequential advance, and redirects from later stages (branches, traps). Obeys the common hazard/backpressure signals (stall, flush, downstream ready) so F2 never sees a dropped or duplicated address.

## Interface
- `RESET_PC`, default `32'h00000000`: address of the first fetch after reset.
- `i_clk`  in  1  core clock; all state changes on its rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `o_stage_ready`  out  1  F1 can accept a redirect/advance; low only in BOOT.
- `i_stage_flush`  in  1  squash the issued address.
- `i_stage_stall`  in  1  hold all state.
- `i_f2_ready`  in  1  F2 will consume the current output this cycle.
- `i_redirect_valid`  in  1  load a new PC.
- `i_redirect_addr`  in  32  redirect target.
- `o_f1_to_f2`  out  `f1_to_f2_s`  registered `{valid, fetch_addr[31:0], misaligned}`.

## Operation
- Registers: `pc_q` (next address to issue), output register `o_f1_to_f2`, `state_q` ∈ {BOOT, RUN, MISALIGN_WAIT}.
- Reset values: `pc_q=RESET_PC`, `o_f1_to_f2.valid=0`, `fetch_addr=32'h0`, `misaligned=0`, `state_q=BOOT`.
- Advance condition `adv = !i_stage_stall && i_f2_ready`.
- Per-cycle priority, highest first: redirect > flush > stall/not-ready hold > advance.
- BOOT: output invalid; unconditionally -> RUN next cycle. Redirect/flush are ignored in BOOT.
- RUN, redirect: `pc_q <= target`, `valid <= 0` (one bubble). This happens even if stalled.
- RUN, flush without redirect: `valid <= 0`. If the output was valid, `pc_q <= fetch_addr` so the squashed address is replayed. Otherwise `pc_q` is unchanged.
- RUN, adv: `o_f1_to_f2 <= {1, pc_q, 0}`, `pc_q <= pc_q + 4`.
- RUN, !adv: output and `pc_q` hold.
- PC arithmetic is 32-bit modulo 2^32: `32'hFFFFFFFC + 4 = 32'h00000000`, with no flag.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronously).

## Timing
- Address becomes visible at F2 one cycle after the advance edge. There is no combinational path from any input to `o_f1_to_f2`.
- `o_stage_ready` is a combinational decode of `state_q` only.
- Redirect to first valid output: 2 cycles with no stall (redirect edge, then advance edge).
- First valid output after reset release: at the second rising edge (BOOT edge, then advance edge).
- Throughput: one address per cycle while `adv` is held high.

## Configuration
- `LETC_CORE_F1_MISALIGN_CHECK_EN` defined:
  - A redirect with `target[1:0] != 0` loads `pc_q`.
  - The next advance emits `{valid=1, fetch_addr=target, misaligned=1}`, then the state goes to MISALIGN_WAIT.
  - MISALIGN_WAIT: output invalid after F2 consumes the flagged entry; no further issue. Only a redirect leaves this state (-> RUN). Flush clears `valid` only.
- Macro undefined:
  - `target[1:0]` is forced to `2'b00` on load.
  - `misaligned` is tied to 0.
  - MISALIGN_WAIT is unreachable and may be omitted.

## Structure
- `letc_core_pkg` holds:
  - `f1_to_f2_s` with fields valid, fetch_addr, misaligned.
  - `pc_t` (`logic [31:0]`).
  - `f1_state_e`.
  - Constant `PC_INCR = 32'd4`.
- Single module with no sub-module. The next-PC mux is small enough to stay inline.

## Test plan
- Reset release, `adv` held high, `RESET_PC=32'h100` -> output invalid for the first edge, then `fetch_addr` 0x100, 0x104, 0x108 on consecutive cycles with `valid=1`.
- After issuing 0x104, drop `i_f2_ready` for 3 cycles -> output holds `{1, 0x104}`; 0x108 appears the cycle after ready returns.
- Redirect to 0x2000 while `i_stage_stall=1`, then release the stall -> one invalid cycle, then 0x2000, 0x2004. Asserting flush in the same cycle has no extra effect.
- Flush alone while the output is `{1, 0x40}` -> valid drops next cycle; the next advance re-emits 0x40.
- `pc_q=32'hFFFFFFFC` with `adv` high -> outputs 0xFFFFFFFC, then 0x00000000.
- With the macro defined, redirect to 0x1002 -> one output `{1, 0x1002, misaligned=1}`, then invalid until a redirect to 0x3000, which resumes issue at 0x3000. Without the macro, the same stimulus emits 0x1000, 0x1004.
